bmem_arbiter: RTL

//  Shares the single burst-memory port (bmem) between I-cache line refills and D-cache refills/writebacks.

---
 rtl/bmem_arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/bmem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bmem_arb_pkg.sv
// Shared types, defaults and helpers for the burst-memory arbiter.
package bmem_arb_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_BEAT_W    = 64;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_DATA,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // Number of byte-offset bits inside one cacheline.
    function automatic int line_offset(input int beat_w, input int burst_len);
        return $clog2((beat_w * burst_len) / 8);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the I-cache and bit 1 is the D-cache.
// The grant is one-hot, or zero when nothing is requesting. After reset the
// D-cache wins a tie. After every taken grant, the requester that was not
// served gets priority for the next tie.
module rr_arb2
    import bmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    req_id_t prio;

    // A lone requester is granted directly; a tie goes to the priority holder.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (prio == REQ_D) ? 2'b10 : 2'b01;
        end
    end

    // Priority moves to whichever requester was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= REQ_D;
        end else if (advance && (gnt != 2'b00)) begin
            prio <= gnt[0] ? REQ_D : REQ_I;
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one burst-memory port between I-cache refills and D-cache
// refills and writebacks. Each cacheline request becomes a burst of
// BURST_LEN beats, with at most one burst in flight at a time.
// Both refill outputs are driven from one shared line buffer.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int  ADDR_W    = DEF_ADDR_W,
    parameter int  BEAT_W    = DEF_BEAT_W,
    parameter int  BURST_LEN = DEF_BURST_LEN,
    localparam int LINE_W    = BEAT_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp,
    output logic              error
);

    localparam int OFF_W = line_offset(BEAT_W, BURST_LEN);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    arb_state_t        state;
    req_id_t           gnt_id;
    logic              op_write;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [LINE_W-1:0] line_buf;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              advance;
    logic              new_write;
    logic              granted_req;
    logic [ADDR_W-1:0] line_addr;
    int                cur_base;
    int                next_base;

    assign req     = {d_read | d_write, i_read};
    assign i_rdata = line_buf;
    assign d_rdata = line_buf;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .gnt     (gnt)
    );

    // Decode the grant, the aligned line address, and the beat slice positions.
    // A D-cache request with both read and write high is treated as a read.
    always_comb begin
        advance     = (state == IDLE);
        new_write   = gnt[1] & d_write & ~d_read;
        line_addr   = (gnt[1] ? d_addr : i_addr) & ~OFF_MASK;
        cnt_next    = cnt + CNT_W'(1);
        cur_base    = int'(cnt) * BEAT_W;
        next_base   = int'(cnt_next) * BEAT_W;
        granted_req = (gnt_id == REQ_I) ? i_read : (op_write ? d_write : d_read);
    end

    // Burst FSM with registered bmem and response outputs, plus the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_id     <= REQ_I;
            op_write   <= 1'b0;
            cnt        <= '0;
            line_buf   <= '0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (bmem_resp && (state != RD_DATA)) begin
                error <= 1'b1;
            end
            if (d_read && d_write) begin
                error <= 1'b1;
            end
            if (((state == RD_CMD) || (state == RD_DATA) || (state == WR_DATA)) && !granted_req) begin
                error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        gnt_id    <= gnt[1] ? REQ_D : REQ_I;
                        op_write  <= new_write;
                        bmem_addr <= line_addr;
                        cnt       <= '0;
                        if (new_write) begin
                            line_buf   <= d_wdata;
                            bmem_write <= 1'b1;
                            bmem_wdata <= d_wdata[BEAT_W-1:0];
                            state      <= WR_DATA;
                        end else begin
                            bmem_read <= 1'b1;
                            state     <= RD_CMD;
                        end
                    end
                end
                RD_CMD: begin
                    bmem_read <= 1'b0;
                    state     <= RD_DATA;
                end
                RD_DATA: begin
                    if (bmem_resp) begin
                        line_buf[cur_base +: BEAT_W] <= bmem_rdata;
                        cnt <= cnt_next;
                        if (cnt == LAST_BEAT) begin
                            bmem_addr <= '0;
                            state     <= DONE;
                            if (gnt_id == REQ_D) begin
                                d_resp <= 1'b1;
                            end else begin
                                i_resp <= 1'b1;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (cnt == LAST_BEAT) begin
                        bmem_write <= 1'b0;
                        bmem_wdata <= '0;
                        bmem_addr  <= '0;
                        cnt        <= '0;
                        state      <= DONE;
                        if (gnt_id == REQ_D) begin
                            d_resp <= 1'b1;
                        end else begin
                            i_resp <= 1'b1;
                        end
                    end else begin
                        cnt        <= cnt_next;
                        bmem_wdata <= line_buf[next_base +: BEAT_W];
                    end
                end
                DONE: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
